// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor states for the traffic conflict monitor.
// Latency: none (types/constants only). Backpressure: not applicable.
package traffic_pkg;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ENCODING = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;

    typedef enum logic [1:0] {
        RED = 2'd0,
        YEL = 2'd1,
        GRN = 2'd2,
        BAD = 2'd3
    } colour_e;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic red;
        logic yel;
        logic grn;
    } lamp_t;

    localparam lamp_t LAMP_RED = 3'b100;

    // Anything other than exactly one lamp lit is BAD.
    function automatic colour_e decode_lamp(input lamp_t l);
        colour_e c;
        case (l)
            3'b100:  c = RED;
            3'b010:  c = YEL;
            3'b001:  c = GRN;
            default: c = BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/traffic_lamp_checker.sv
// Per-direction lamp checker: colour decode, encoding flag, yellow run and sequence flag.
// Latency: flags combinational from the registered lamps; history updates next edge. No backpressure.
module traffic_lamp_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  lamp_t lamp_i,
    input  logic  upd_en_i,
    input  logic  restore_i,
    output logic  enc_err_o,
    output logic  seq_err_o
);

    colour_e    colour;
    colour_e    prev_q, prev_d;
    logic [3:0] yel_cnt_q, yel_cnt_d;

    always_comb begin
        colour    = decode_lamp(lamp_i);
        enc_err_o = (colour == BAD);
        seq_err_o = ((prev_q == GRN) && (colour == RED)) ||
                    ((prev_q == RED) && (colour == YEL)) ||
                    ((prev_q == YEL) && (colour == GRN)) ||
                    ((prev_q == YEL) && (colour == RED) && (yel_cnt_q < 4'(MIN_YELLOW)));

        yel_cnt_d = 4'd0;
        if (colour == YEL) begin
            yel_cnt_d = (yel_cnt_q == 4'(MIN_YELLOW)) ? yel_cnt_q : yel_cnt_q + 4'd1;
        end

        // History only ever holds legal colours, so BAD never becomes "previous".
        prev_d = prev_q;
        if (restore_i) begin
            prev_d = RED;
        end else if (upd_en_i && !enc_err_o && !seq_err_o) begin
            prev_d = colour;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= RED;
            yel_cnt_q <= 4'd0;
        end else begin
            prev_q    <= prev_d;
            yel_cnt_q <= yel_cnt_d;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the light controller and lamps: mirrors legal patterns, flashes red on faults.
// Latency: 1 cycle input to lamp in PASS. Backpressure: none, samples every cycle.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FLASH_HALF    = 4,
    parameter int FAULT_PERSIST = 2,
    parameter int MIN_YELLOW    = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       NS_RED_IN,
    input  logic       NS_YELLOW_IN,
    input  logic       NS_GREEN_IN,
    input  logic       EW_RED_IN,
    input  logic       EW_YELLOW_IN,
    input  logic       EW_GREEN_IN,
    input  logic       CLEAR,
    output logic       NS_RED,
    output logic       NS_YELLOW,
    output logic       NS_GREEN,
    output logic       EW_RED,
    output logic       EW_YELLOW,
    output logic       EW_GREEN,
    output logic       FAULT,
    output logic [2:0] FAULT_CODE
);

    localparam logic [8:0] CLEAN_LAST = 9'(2 * FLASH_HALF - 1);
    localparam logic [7:0] HALF_LAST  = 8'(FLASH_HALF - 1);

    lamp_t      ns_q, ew_q;
    mon_state_e state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [3:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [8:0] clean_q, clean_d;
    logic [7:0] fcnt_q;
    logic       phase_q;

    logic ns_enc, ew_enc, ns_seq, ew_seq;
    logic conflict, persist_err, trip, all_red;
    logic upd_en, restore, flash_start;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ns_q <= LAMP_RED;
            ew_q <= LAMP_RED;
        end else begin
            ns_q <= '{red: NS_RED_IN, yel: NS_YELLOW_IN, grn: NS_GREEN_IN};
            ew_q <= '{red: EW_RED_IN, yel: EW_YELLOW_IN, grn: EW_GREEN_IN};
        end
    end

    traffic_lamp_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_chk (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .lamp_i    (ns_q),
        .upd_en_i  (upd_en),
        .restore_i (restore),
        .enc_err_o (ns_enc),
        .seq_err_o (ns_seq)
    );

    traffic_lamp_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_chk (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .lamp_i    (ew_q),
        .upd_en_i  (upd_en),
        .restore_i (restore),
        .enc_err_o (ew_enc),
        .seq_err_o (ew_seq)
    );

    always_comb begin
        conflict    = (ns_q.yel | ns_q.grn) & (ew_q.yel | ew_q.grn);
        persist_err = conflict | ns_enc | ew_enc;
        all_red     = (ns_q == LAMP_RED) && (ew_q == LAMP_RED);
        upd_en      = (state_q == PASS) && !conflict;
        pcnt_inc    = pcnt_q + 4'd1;
        trip        = (persist_err && (pcnt_inc == 4'(FAULT_PERSIST))) || ns_seq || ew_seq;
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        clean_d     = clean_q;
        pcnt_d      = 4'd0;
        restore     = 1'b0;
        flash_start = 1'b0;
        case (state_q)
            PASS: begin
                pcnt_d = persist_err ? pcnt_inc : 4'd0;
                if (trip) begin
                    state_d     = FLASH;
                    flash_start = 1'b1;
                    pcnt_d      = 4'd0;
                    if (conflict)               code_d = FC_CONFLICT;
                    else if (ns_enc || ew_enc)  code_d = FC_ENCODING;
                    else                        code_d = FC_SEQUENCE;
                end
            end
            FLASH: begin
                clean_d = 9'd0;
                if (CLEAR) state_d = RECOVER;
            end
            RECOVER: begin
                if (!all_red) begin
                    state_d = FLASH;
                    clean_d = 9'd0;
                end else if (clean_q == CLEAN_LAST) begin
                    state_d = PASS;
                    code_d  = FC_NONE;
                    clean_d = 9'd0;
                    restore = 1'b1;
                end else begin
                    clean_d = clean_q + 9'd1;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= PASS;
            code_q  <= FC_NONE;
            pcnt_q  <= 4'd0;
            clean_q <= 9'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pcnt_q  <= pcnt_d;
            clean_q <= clean_d;
        end
    end

    // Phase restarts only on a fresh trip; RECOVER<->FLASH bounces keep the cadence.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q <= 1'b1;
            fcnt_q  <= 8'd0;
        end else if (flash_start) begin
            phase_q <= 1'b1;
            fcnt_q  <= 8'd0;
        end else if (state_q != PASS) begin
            if (fcnt_q == HALF_LAST) begin
                fcnt_q  <= 8'd0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        FAULT      = (state_q != PASS);
        FAULT_CODE = code_q;
        if (state_q == PASS) begin
            {NS_RED, NS_YELLOW, NS_GREEN} = ns_q;
            {EW_RED, EW_YELLOW, EW_GREEN} = ew_q;
        end else begin
            {NS_RED, NS_YELLOW, NS_GREEN} = {phase_q, 2'b00};
            {EW_RED, EW_YELLOW, EW_GREEN} = {phase_q, 2'b00};
        end
    end

endmodule
